// File: rtl/reg_scoreboard_if.sv
// Issue/retire/flush bundle between decode, writeback and the register scoreboard.
interface reg_scoreboard_if;
    logic       issue_valid;
    logic       issue_ld_reg;
    logic [2:0] issue_drid;
    logic       issue_ld_cc;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       sr1_needed;
    logic       sr2_needed;
    logic       br_cc_needed;
    logic       retire_valid;
    logic       retire_ld_reg;
    logic       retire_ld_cc;
    logic [2:0] retire_drid;
    logic       flush;
    logic       dep_stall;
    logic       issue_fire;
    logic [7:0] reg_busy;
    logic       cc_busy;
    logic       sb_error;

    modport master (
        output issue_valid, issue_ld_reg, issue_drid, issue_ld_cc,
               sr1, sr2, sr1_needed, sr2_needed, br_cc_needed,
               retire_valid, retire_ld_reg, retire_ld_cc, retire_drid, flush,
        input  dep_stall, issue_fire, reg_busy, cc_busy, sb_error
    );

    modport slave (
        input  issue_valid, issue_ld_reg, issue_drid, issue_ld_cc,
               sr1, sr2, sr1_needed, sr2_needed, br_cc_needed,
               retire_valid, retire_ld_reg, retire_ld_cc, retire_drid, flush,
        output dep_stall, issue_fire, reg_busy, cc_busy, sb_error
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for R0..R7 plus CC; counters 0..7 are registers, 8 is CC.
// Optional macro SCOREBOARD_RETIRE_BYPASS_EN: a count-1 entry retiring this cycle does not stall.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt_nxt;

    // Coincident inc/dec cancel, so saturation is only an error when unopposed.
    always_comb begin
        cnt_nxt = cnt;
        err     = 1'b0;
        if (inc && !dec) begin
            if (cnt == MAX) err = 1'b1;
            else            cnt_nxt = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        cnt <= '0;
        else if (flush) cnt <= '0;
        else            cnt <= cnt_nxt;
    end
endmodule

module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input logic            clk,
    input logic            rst,
    reg_scoreboard_if.slave sb
);
    logic [8:0][CNT_W-1:0] cnt;
    logic [8:0]            inc;
    logic [8:0]            dec;
    logic [8:0]            err;
    logic [8:0]            busy;
    logic [8:0]            hazard;
    logic [7:0]            reg_haz;
    logic                  fire;
    logic                  sb_error_q;

    genvar g;
    for (g = 0; g < 8; g++) begin : g_reg
        assign inc[g] = fire & sb.issue_ld_reg & (sb.issue_drid == 3'(g));
        assign dec[g] = sb.retire_valid & sb.retire_ld_reg & (sb.retire_drid == 3'(g));
    end
    assign inc[8] = fire & sb.issue_ld_cc;
    assign dec[8] = sb.retire_valid & sb.retire_ld_cc;

    for (g = 0; g < 9; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .flush (sb.flush),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .cnt   (cnt[g]),
            .err   (err[g])
        );
        assign busy[g] = |cnt[g];
`ifdef SCOREBOARD_RETIRE_BYPASS_EN
        // Last outstanding write lands this cycle; writeback forwards it.
        assign hazard[g] = busy[g] & ~(dec[g] & (cnt[g] == CNT_W'(1)));
`else
        assign hazard[g] = busy[g];
`endif
    end

    assign reg_haz      = hazard[7:0];
    assign sb.dep_stall = sb.issue_valid & ((sb.sr1_needed & reg_haz[sb.sr1]) |
                                            (sb.sr2_needed & reg_haz[sb.sr2]) |
                                            (sb.br_cc_needed & hazard[8]));
    assign fire          = sb.issue_valid & ~sb.dep_stall;
    assign sb.issue_fire = fire;
    assign sb.reg_busy   = busy[7:0];
    assign sb.cc_busy    = busy[8];
    assign sb.sb_error   = sb_error_q;

    // Flush discards in-flight updates, so an error on a squashed update is ignored.
    always_ff @(posedge clk) begin
        if (rst)                     sb_error_q <= 1'b0;
        else if (|err && !sb.flush)  sb_error_q <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector bench for reg_scoreboard: per-cycle inputs with expected outputs seen before the edge.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    reg_scoreboard_if sb ();
    reg_scoreboard #(.CNT_W(2)) dut (.clk(clk), .rst(rst), .sb(sb));

    always #5 clk = ~clk;

`ifdef SCOREBOARD_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit       rst;
        bit       iv, ild, icc;
        bit [2:0] idr, s1, s2;
        bit       n1, n2, bcc;
        bit       rv, rld, rcc;
        bit [2:0] rdr;
        bit       fl;
        bit       st, fi;
        bit [7:0] busy;
        bit       ccb, err;
    } vec_t;

    function automatic vec_t mk(bit r, bit iv, bit ild, bit icc, bit [2:0] idr,
                                bit [2:0] s1, bit n1, bit [2:0] s2, bit n2, bit bcc,
                                bit rv, bit rld, bit rcc, bit [2:0] rdr, bit fl,
                                bit st, bit fi, bit [7:0] busy, bit ccb, bit err);
        vec_t v;
        v.rst = r; v.iv = iv; v.ild = ild; v.icc = icc; v.idr = idr;
        v.s1 = s1; v.n1 = n1; v.s2 = s2; v.n2 = n2; v.bcc = bcc;
        v.rv = rv; v.rld = rld; v.rcc = rcc; v.rdr = rdr; v.fl = fl;
        v.st = st; v.fi = fi; v.busy = busy; v.ccb = ccb; v.err = err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst             = v.rst;
        sb.issue_valid  = v.iv;  sb.issue_ld_reg = v.ild; sb.issue_ld_cc = v.icc;
        sb.issue_drid   = v.idr; sb.sr1 = v.s1; sb.sr2 = v.s2;
        sb.sr1_needed   = v.n1;  sb.sr2_needed = v.n2; sb.br_cc_needed = v.bcc;
        sb.retire_valid = v.rv;  sb.retire_ld_reg = v.rld; sb.retire_ld_cc = v.rcc;
        sb.retire_drid  = v.rdr; sb.flush = v.fl;
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {stall,fire,busy,cc,err}=%b expected %b", name, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {sb.dep_stall, sb.issue_fire, sb.reg_busy, sb.cc_busy, sb.sb_error};
    endfunction

    // Drive at posedge+1, compare at negedge, advance to next posedge+1.
    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        check(name, outs(), {v.st, v.fi, v.busy, v.ccb, v.err});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[28];
    vec_t idle;

    initial begin
        //              r iv ld cc idr s1 n1 s2 n2 bc rv rl rc rdr fl | st      fi     busy  cc er
        idle     = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     0,     8'h00, 0, 0);
        vecs[0]  = idle;
        vecs[1]  = mk(0, 1, 1, 1, 3,  1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h00, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h08, 1, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0, 0,  0,  1,     0,     8'h08, 1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0,  3, 1, 0, 0, 0, 1, 1, 0, 3,  0,  !BYP,  BYP,   8'h08, 1, 0);
        vecs[5]  = mk(0, 1, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h00, 1, 0);
        vecs[6]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0,  0,  1,     0,     8'h00, 1, 0);
        vecs[7]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 1, 0,  0,  !BYP,  BYP,   8'h00, 1, 0);
        vecs[8]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0,  0,  0,     1,     8'h00, 0, 0);
        vecs[9]  = mk(0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h00, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h20, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h20, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h20, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  1,  0,     0,     8'h20, 0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     0,     8'h00, 0, 1);
        vecs[15] = mk(0, 1, 1, 0, 5,  5, 1, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h00, 0, 1);
        vecs[16] = mk(0, 1, 1, 0, 5,  5, 1, 0, 0, 0, 0, 0, 0, 0,  0,  1,     0,     8'h20, 0, 1);
        vecs[17] = mk(0, 1, 1, 0, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h20, 0, 1);
        vecs[18] = mk(0, 1, 1, 0, 2,  0, 0, 5, 0, 0, 1, 1, 0, 2,  0,  0,     1,     8'h24, 0, 1);
        vecs[19] = mk(0, 1, 0, 0, 0,  0, 0, 2, 1, 0, 0, 0, 0, 0,  0,  1,     0,     8'h24, 0, 1);
        vecs[20] = mk(0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h24, 0, 1);
        vecs[21] = mk(0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     1,     8'h26, 1, 1);
        vecs[22] = mk(0, 1, 1, 1, 4,  0, 0, 0, 0, 0, 1, 1, 0, 2,  1,  0,     1,     8'h26, 1, 1);
        vecs[23] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     0,     8'h00, 0, 1);
        vecs[24] = mk(1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 1, 1, 1, 7,  1,  0,     1,     8'h00, 0, 1);
        vecs[25] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     0,     8'h00, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0, 6,  0,  0,     0,     8'h00, 0, 0);
        vecs[27] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0,     0,     8'h00, 0, 1);

        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 28; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Saturated counter with coincident retire must not flag an error.
        idle.rst = 1'b1; drive(idle); @(posedge clk); #1; idle.rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
        end
        drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("sat_inc_dec_pre", outs(), {1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            check($sformatf("drain%0d", i), outs(), {1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
            @(posedge clk); #1;
        end
        // Issue and retire at zero cancel: no underflow.
        drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("zero_inc_dec_pre", outs(), {1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        @(posedge clk); #1;
        drive(idle);
        @(negedge clk);
        check("zero_inc_dec_post", outs(), {1'b0, 1'b0, 8'h00, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: CNT_W, 2, width of each per-register pending-write counter (max in-flight writes = 2**CNT_W-1).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 issue_valid  input  1  decode-stage instruction presented for issue.
REQ-005 issue_ld_reg  input  1  issuing instruction writes a register.
REQ-006 issue_drid  input  3 (lc3b_reg)  issuing destination register.
REQ-007 issue_ld_cc  input  1  issuing instruction writes condition codes.
REQ-008 sr1, sr2  input  3 each (lc3b_reg)  issuing source registers.
REQ-009 sr1_needed, sr2_needed  input  1 each  source actually read.
REQ-010 br_cc_needed  input  1  issuing instruction is a conditional branch reading CC.
REQ-011 retire_valid  input  1  writeback-stage instruction completes this cycle.
REQ-012 retire_ld_reg, retire_ld_cc  input  1 each  retiring instruction writes register / CC.
REQ-013 retire_drid  input  3 (lc3b_reg)  retiring destination register.
REQ-014 flush  input  1  whole-pipeline squash; all in-flight writes discarded.
REQ-015 dep_stall  output  1  issue must be held this cycle.
REQ-016 issue_fire  output  1  issue accepted this cycle (issue_valid & ~dep_stall).
REQ-017 reg_busy  output  8  bit n = counter for Rn nonzero.
REQ-018 cc_busy  output  1  CC counter nonzero.
REQ-019 sb_error  output  1  sticky overflow/underflow flag.

Function
REQ-020 Block SHALL hold eight CNT_W-bit register counters and one CNT_W-bit CC counter, all registered.
REQ-021 dep_stall SHALL be combinational from registered counters: issue_valid & ((sr1_needed & busy[sr1]) | (sr2_needed & busy[sr2]) | (br_cc_needed & cc_busy)).
REQ-022 On issue_fire & issue_ld_reg, counter[issue_drid] SHALL increment at next edge; likewise CC counter on issue_fire & issue_ld_cc.
REQ-023 On retire_valid & retire_ld_reg, counter[retire_drid] SHALL decrement at next edge; likewise CC counter on retire_valid & retire_ld_cc.
REQ-024 Issue and retire to same counter in one cycle SHALL leave it unchanged.
REQ-025 Increment at 2**CNT_W-1 without coincident retire SHALL hold value and set sb_error.
REQ-026 Decrement at 0 without coincident issue SHALL hold 0 and set sb_error.
REQ-027 Self-dependency (issue_drid equal to a needed source) SHALL stall only on pre-issue counter state.
REQ-028 flush SHALL clear all counters at next edge, overriding same-cycle issue and retire; dep_stall and issue_fire are still computed from current state that cycle.
REQ-029 sb_error SHALL remain set until rst; flush SHALL NOT clear it.
REQ-030 issue_fire SHALL be 0 whenever issue_valid is 0; counters SHALL never change without issue_fire, retire_valid or flush.

Reset
REQ-031 On rst at clock edge: all counters 0, sb_error 0; thereafter reg_busy=8'h00, cc_busy=0, dep_stall=0.
REQ-032 rst SHALL take priority over flush, issue and retire in the same cycle.

Configuration
REQ-033 Macro SCOREBOARD_RETIRE_BYPASS_EN: when defined, a register or CC whose counter equals 1 and is retiring this same cycle SHALL be treated as not busy for dep_stall (same-cycle writeback forwarding); when undefined, dep_stall uses registered counters only, costing one extra stall cycle.
REQ-034 reg_busy and cc_busy SHALL reflect registered counters in both configurations.

Verification
REQ-035 Reset, then issue ADD R3 (ld_reg, ld_cc) -> next cycle reg_busy=8'h08, cc_busy=1, dep_stall=0 for an instruction reading only R1.
REQ-036 R3 busy (count 1), issue sr1=R3 sr1_needed=1 -> dep_stall=1, issue_fire=0; retire R3 -> bypass build: stall drops same cycle; non-bypass: next cycle.
REQ-037 Issue to R5 three times with no retire (CNT_W=2) -> counter 3; fourth issue -> counter stays 3, sb_error=1 persists across flush.
REQ-038 Simultaneous issue R2 and retire R2 with counter 1 -> counter stays 1, reg_busy[2]=1.
REQ-039 Counters R1=2, CC=1, assert flush with issue_fire to R4 -> next cycle reg_busy=8'h00, cc_busy=0.
REQ-040 CC busy, br_cc_needed=1 with sr1_needed=sr2_needed=0 -> dep_stall=1; retire_ld_cc -> cc_busy=0 and dep_stall=0 in the cycle after the retire edge.
